// File: rtl/nabp_projection_filter.sv
// Ramp (Ram-Lak) FIR for one projection line: symmetric pre-add, multiply, adder tree,
// round-half-up and saturate, emitting sample-indexed filtered values 3 cycles after launch.
module nabp_projection_filter #(
  parameter int DATA_LEN          = 8,
  parameter int FILTERED_DATA_LEN = 12,
  parameter int S_LEN             = 8,
  parameter int LINE_SIZE         = 128,
  parameter int HALF              = 4,
  parameter int COEFF_FRAC        = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                line_start,
  input  logic                                in_valid,
  input  logic        [DATA_LEN-1:0]          in_data,
  output logic                                out_valid,
  output logic signed [FILTERED_DATA_LEN-1:0] out_data,
  output logic        [S_LEN-1:0]             out_s,
  output logic                                out_last,
  output logic                                line_done,
  output logic                                busy
);

  localparam int TAPS  = 2 * HALF + 1;
  localparam int ACC_W = DATA_LEN + COEFF_FRAC + $clog2(TAPS) + 2;
  localparam int CW    = COEFF_FRAC + 3;
  localparam int FC_W  = (HALF > 1) ? $clog2(HALF) : 1;

  // Ramp coefficients: c0 = round(2^F/4), odd k: -round(2^F/(k^2*pi^2)), even k: 0.
  // pi^2 is carried as 98696044e-7 so the rounding stays in integer arithmetic.
  function automatic int coeff_of(input int k);
    longint scale;
    longint den;
    scale = longint'(1) << COEFF_FRAC;
    if (k == 0) return int'((scale + 2) / 4);
    if (k % 2 == 0) return 0;
    den = longint'(k) * longint'(k) * longint'(98696044);
    return -int'((scale * 20000000 + den) / (2 * den));
  endfunction

  function automatic logic [(HALF+1)*CW-1:0] build_coeffs();
    logic [(HALF+1)*CW-1:0] v;
    v = '0;
    for (int k = 0; k <= HALF; k++) v[k*CW +: CW] = CW'(coeff_of(k));
    return v;
  endfunction

  localparam logic [(HALF+1)*CW-1:0] COEFFS = build_coeffs();

  localparam longint SAT_MAX_L = (longint'(1) << (FILTERED_DATA_LEN - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(SAT_MAX_L);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-SAT_MAX_L - 1);
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(longint'(1) << (COEFF_FRAC - 1));

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DRAIN} state_t;

  state_t                state;
  logic [S_LEN-1:0]      n_cnt;
  logic [FC_W-1:0]       f_cnt;
  logic                  launch;
  logic [DATA_LEN-1:0]   taps [TAPS];

  logic                  shift_en;
  logic                  clear_taps;
  logic [DATA_LEN-1:0]   shift_data;

  logic signed [ACC_W-1:0] coef_ext  [HALF+1];
  logic signed [ACC_W-1:0] pre_sum   [HALF+1];
  logic signed [ACC_W-1:0] prod_next [HALF+1];
  logic signed [ACC_W-1:0] prod      [HALF+1];
  logic                    prod_valid;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] sat_value;
  logic [S_LEN-1:0]        s_cnt;

  assign busy = (state != IDLE);

  // NOTE: every variable driven here gets a value on all paths, so no latch is inferred.
  always_comb begin
    clear_taps = (state == IDLE) && line_start;
    shift_en   = (((state == PRIME) || (state == STREAM)) && in_valid) || (state == FLUSH);
    shift_data = (state == FLUSH) ? '0 : in_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      n_cnt  <= '0;
      f_cnt  <= '0;
      launch <= 1'b0;
    end else begin
      launch <= 1'b0;
      case (state)
        IDLE: begin
          if (line_start) begin
            state <= PRIME;
            n_cnt <= '0;
            f_cnt <= '0;
          end
        end
        PRIME: begin
          if (in_valid) begin
            n_cnt <= n_cnt + 1'b1;
            if (n_cnt == S_LEN'(HALF - 1)) state <= STREAM;
          end
        end
        STREAM: begin
          if (in_valid) begin
            launch <= 1'b1;
            n_cnt  <= n_cnt + 1'b1;
            if (n_cnt == S_LEN'(LINE_SIZE - 1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          launch <= 1'b1;
          f_cnt  <= f_cnt + 1'b1;
          if (f_cnt == FC_W'(HALF - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (line_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the delay line is a small register bank, not a RAM, so it is reset explicitly;
  // stale taps would otherwise leak into the zero-padded edge of the next line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (clear_taps) begin
      for (int i = 0; i < TAPS; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= shift_data;
      for (int i = 1; i < TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  // taps[HALF] holds x[s]; taps[HALF-k] and taps[HALF+k] hold x[s+k] and x[s-k].
  always_comb begin
    for (int k = 0; k <= HALF; k++) begin
      coef_ext[k] = ACC_W'($signed(COEFFS[k*CW +: CW]));
      if (k == 0) pre_sum[k] = ACC_W'(taps[HALF]);
      else        pre_sum[k] = ACC_W'(taps[HALF-k]) + ACC_W'(taps[HALF+k]);
      prod_next[k] = pre_sum[k] * coef_ext[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_valid <= 1'b0;
      for (int k = 0; k <= HALF; k++) prod[k] <= '0;
    end else begin
      prod_valid <= launch;
      for (int k = 0; k <= HALF; k++) prod[k] <= prod_next[k];
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k <= HALF; k++) acc = acc + prod[k];
    rounded = (acc + ROUND_BIAS) >>> COEFF_FRAC;
    if (rounded > SAT_MAX)      sat_value = SAT_MAX;
    else if (rounded < SAT_MIN) sat_value = SAT_MIN;
    else                        sat_value = rounded;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_s     <= '0;
      out_last  <= 1'b0;
      line_done <= 1'b0;
      s_cnt     <= '0;
    end else begin
      out_valid <= prod_valid;
      line_done <= out_valid && out_last;
      if (clear_taps) s_cnt <= '0;
      if (prod_valid) begin
        out_data <= FILTERED_DATA_LEN'(sat_value);
        out_s    <= s_cnt;
        out_last <= (s_cnt == S_LEN'(LINE_SIZE - 1));
        s_cnt    <= s_cnt + 1'b1;
      end else begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nabp_projection_filter.sv
// Bench for nabp_projection_filter: a 12-bit and a 6-bit (saturating) instance share stimulus;
// outputs, indices and timing are compared against a direct convolution model of the ramp filter.
module tb_nabp_projection_filter;

  localparam int L      = 16;
  localparam int H      = 4;
  localparam int FW     = 12;
  localparam int FW_SAT = 6;
  localparam int SL     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic                 out_valid, out_last, line_done, busy;
  logic signed [FW-1:0] out_data;
  logic [SL-1:0]        out_s;

  logic                     sat_valid, sat_last, sat_done, sat_busy;
  logic signed [FW_SAT-1:0] sat_data;
  logic [SL-1:0]            sat_s;

  nabp_projection_filter #(
    .DATA_LEN(8), .FILTERED_DATA_LEN(FW), .S_LEN(SL), .LINE_SIZE(L), .HALF(H), .COEFF_FRAC(8)
  ) dut (
    .clk(clk), .reset(rst), .line_start(line_start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_s(out_s), .out_last(out_last),
    .line_done(line_done), .busy(busy)
  );

  nabp_projection_filter #(
    .DATA_LEN(8), .FILTERED_DATA_LEN(FW_SAT), .S_LEN(SL), .LINE_SIZE(L), .HALF(H), .COEFF_FRAC(8)
  ) dut_sat (
    .clk(clk), .reset(rst), .line_start(line_start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(sat_valid), .out_data(sat_data), .out_s(sat_s), .out_last(sat_last),
    .line_done(sat_done), .busy(sat_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [31:0] data;
    logic signed [31:0] sdata;
    logic signed [31:0] s;
    logic               last;
    logic               svalid;
    int                 cyc;
  } obs_t;

  obs_t obs_q[$];
  int   done_count = 0;

  always @(negedge clk) begin
    if (out_valid)
      obs_q.push_back('{data: 32'(out_data), sdata: 32'(sat_data), s: 32'(out_s),
                        last: out_last, svalid: sat_valid, cyc: cyc});
    if (line_done) done_count++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  int xin[L];
  int acc_cyc[L];
  int ctab[H+1] = '{64, -26, 0, -3, 0};

  // y[s] = sum_j c_|j| * x[s+j] with zero padding, then round half up and clamp.
  function automatic int model_y(input int s, input int fw);
    int acc;
    int r;
    int lim;
    acc = 0;
    for (int j = -H; j <= H; j++) begin
      int n;
      n = s + j;
      if (n >= 0 && n < L) acc += ctab[(j < 0) ? -j : j] * xin[n];
    end
    r = (acc + 128) >>> 8;
    lim = 1 << (fw - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return r;
  endfunction

  task automatic run_line(input bit gaps, input bit mid_start, input bit junk_tail,
                          input bit start_on_done);
    int  done_cyc;
    int  exp_cyc;
    int  n_obs;
    bit  got_done;
    obs_q.delete();
    done_count = 0;
    @(posedge clk); #1; line_start = 1'b1;
    @(posedge clk); #1; line_start = 1'b0;
    for (int n = 0; n < L; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        int g;
        g = $urandom_range(1, 3);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid   = 1'b1;
      in_data    = 8'(xin[n]);
      acc_cyc[n] = cyc;
      if (mid_start && n == 10) line_start = 1'b1;
      @(posedge clk); #1;
      line_start = 1'b0;
    end
    in_valid = junk_tail;
    in_data  = 8'($urandom);
    got_done = 1'b0;
    done_cyc = 0;
    for (int t = 0; t < 40 && !got_done; t++) begin
      if (line_done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        if (start_on_done) line_start = 1'b1;
      end else begin
        @(posedge clk); #1;
        in_data = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("line_done_seen", 32'(got_done), 1);
    @(posedge clk); #1;
    line_start = 1'b0;
    if (start_on_done) check("busy_after_ignored_start", 32'(busy), 0);
    check("line_done_one_cycle", 32'(line_done), 0);
    check("done_count", done_count, 1);
    check("out_count", obs_q.size(), L);
    n_obs = (obs_q.size() < L) ? obs_q.size() : L;
    for (int i = 0; i < n_obs; i++) begin
      exp_cyc = (i < L - H) ? acc_cyc[i + H] + 3 : acc_cyc[L - 1] + 1 + (i - (L - H)) + 3;
      check($sformatf("y[%0d]", i), obs_q[i].data, model_y(i, FW));
      check($sformatf("ysat[%0d]", i), obs_q[i].sdata, model_y(i, FW_SAT));
      check($sformatf("sat_valid[%0d]", i), 32'(obs_q[i].svalid), 1);
      check($sformatf("out_s[%0d]", i), obs_q[i].s, i);
      check($sformatf("out_last[%0d]", i), 32'(obs_q[i].last), (i == L - 1) ? 1 : 0);
      check($sformatf("latency[%0d]", i), obs_q[i].cyc, exp_cyc);
    end
    if (n_obs == L) check("line_done_cycle", done_cyc, obs_q[L - 1].cyc + 1);
  endtask

  task automatic set_impulse(input int v);
    for (int n = 0; n < L; n++) xin[n] = 0;
    xin[8] = v;
  endtask

  task automatic set_random();
    for (int n = 0; n < L; n++) xin[n] = int'($urandom_range(0, 255));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_s", 32'(out_s), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_line_done", 32'(line_done), 0);
    rst = 1'b0;

    // Impulse of 100 at x[8].
    set_impulse(100);
    run_line(1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_q.size() == L) begin
      check("imp_y8", obs_q[8].data, 25);
      check("imp_y7", obs_q[7].data, -10);
      check("imp_y9", obs_q[9].data, -10);
      check("imp_y5", obs_q[5].data, -1);
      check("imp_y11", obs_q[11].data, -1);
      check("imp_y0", obs_q[0].data, 0);
    end

    // Constant 255 line; in_valid held high through FLUSH/DRAIN must be ignored.
    for (int n = 0; n < L; n++) xin[n] = 255;
    run_line(1'b0, 1'b0, 1'b1, 1'b0);
    if (obs_q.size() == L) begin
      check("const_y0", obs_q[0].data, 35);
      check("const_y15", obs_q[15].data, 35);
      check("const_y4", obs_q[4].data, 6);
      check("const_y11", obs_q[11].data, 6);
    end

    // Impulse of 255: the 6-bit instance clamps the centre tap only.
    set_impulse(255);
    run_line(1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_q.size() == L) begin
      check("sat_y8", obs_q[8].sdata, 31);
      check("sat_y7", obs_q[7].sdata, -26);
      check("sat_y9", obs_q[9].sdata, -26);
      check("wide_y8", obs_q[8].data, 64);
    end

    // Random lines with input gaps, a line_start on the line_done cycle, and one mid-line.
    set_random();
    run_line(1'b1, 1'b0, 1'b0, 1'b1);
    set_random();
    run_line(1'b1, 1'b1, 1'b1, 1'b0);
    set_random();
    run_line(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of STREAM abandons the line.
    set_random();
    @(posedge clk); #1; line_start = 1'b1;
    @(posedge clk); #1; line_start = 1'b0;
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(xin[n]);
      @(posedge clk); #1;
    end
    check("busy_in_stream", 32'(busy), 1);
    check("out_valid_in_stream", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("busy_at_reset", 32'(busy), 0);
    check("out_valid_at_reset", 32'(out_valid), 0);
    check("out_last_at_reset", 32'(out_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    done_count = 0;
    repeat (20) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("post_reset_outputs", obs_q.size(), 0);
    check("post_reset_line_done", done_count, 0);
    check("post_reset_busy", 32'(busy), 0);

    set_impulse(100);
    run_line(1'b0, 1'b0, 1'b0, 1'b0);
    if (obs_q.size() == L) check("after_reset_y8", obs_q[8].data, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
